// File: rtl/req_encoder_16x4.sv
// Sequential N-to-CW request encoder: sticky pending register, priority pick, valid/ready code output.
// Optional round-robin priority with REQ_ENC_ROUND_ROBIN_EN; fixed lowest-index priority otherwise.
module req_encoder_16x4 #(
    parameter int N  = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [CW-1:0] code,
    output logic          valid,
    input  logic          ready,
    output logic [N-1:0]  pending,
    output logic [CW:0]   pend_cnt,
    output logic          dup
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    generate
        if (CW != $clog2(N) || N < 2 || N > 16) begin : g_bad_params
            $error("req_encoder_16x4: CW must equal clog2(N), N a power of two in 2..16");
        end
    endgenerate

    // First set bit of vec scanning upward from start, wrapping modulo N.
    function automatic logic [CW-1:0] pick(input logic [N-1:0] vec, input logic [CW-1:0] start);
        logic [CW-1:0] idx;
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = start + CW'(i);
            if (vec[idx]) pick = idx;
        end
    endfunction

    function automatic logic [CW:0] popcnt(input logic [N-1:0] vec);
        popcnt = '0;
        for (int i = 0; i < N; i++) popcnt = popcnt + (CW+1)'(vec[i]);
    endfunction

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [CW:0]   pend_cnt_q, pend_cnt_d;
    logic [CW-1:0] code_q, code_d;
    logic          valid_q, valid_d;
    logic          dup_q, dup_d;
    logic          hs;
    logic [N-1:0]  clr;
    logic [N-1:0]  rem;
    logic [CW-1:0] start;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [CW-1:0] ptr_q, ptr_d;
`endif

    always_comb begin
        hs  = valid_q & ready;
        clr = hs ? (N'(1) << code_q) : '0;
        // A request on the bit being cleared re-arms it in the same edge.
        rem = (pending_q & ~clr) | req;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        ptr_d = hs ? code_q + 1'b1 : ptr_q;
        start = ptr_d;
`else
        start = '0;
`endif
        state_d    = state_q;
        code_d     = code_q;
        valid_d    = valid_q;
        pending_d  = rem;
        pend_cnt_d = popcnt(rem);
        dup_d      = |(req & pending_q & ~clr);
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    code_d  = pick(pending_q, start);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    if (|rem) begin
                        code_d = pick(rem, start);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            pend_cnt_q <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            dup_q      <= 1'b0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            dup_q      <= dup_d;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign code     = code_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign pend_cnt = pend_cnt_q;
    assign dup      = dup_q;

endmodule

// File: tb/tb_req_encoder_16x4.sv
// Self-checking bench for req_encoder_16x4: directed scenarios plus random traffic vs a behavioural model.
module tb_req_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [3:0]  code;
    logic        valid;
    logic        ready;
    logic [15:0] pending;
    logic [4:0]  pend_cnt;
    logic        dup;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state.
    bit [15:0] m_pend;
    bit        m_valid;
    int        m_code;
    bit        m_dup;
    int        m_ptr;

    req_encoder_16x4 #(.N(16), .CW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .pend_cnt (pend_cnt),
        .dup      (dup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pick(input bit [15:0] v, input int p);
        for (int k = 0; k < 16; k++) begin
            if (v[(p + k) % 16]) return (p + k) % 16;
        end
        return 0;
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, compare every output.
    task automatic step(input logic [15:0] r, input logic rd, input logic rs);
        bit        hs;
        bit [15:0] clr;
        bit [15:0] rem;
        req   = r;
        ready = rd;
        rst_n = rs;
        @(posedge clk);
        if (!rs) begin
            m_pend = 0; m_valid = 0; m_code = 0; m_dup = 0; m_ptr = 0;
        end else begin
            hs  = m_valid && rd;
            clr = hs ? (16'd1 << m_code) : 16'd0;
            rem = (m_pend & ~clr) | r;
            m_dup = (r & m_pend & ~clr) != 0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            if (hs) m_ptr = (m_code + 1) % 16;
`endif
            if (!m_valid) begin
                if (m_pend != 0) begin
                    m_code  = pick(m_pend, m_ptr);
                    m_valid = 1;
                end
            end else if (hs) begin
                if (rem != 0) m_code = pick(rem, m_ptr);
                else m_valid = 0;
            end
            m_pend = rem;
        end
        #1;
        chk("pending", pending, m_pend);
        chk("pend_cnt", pend_cnt, $countones(m_pend));
        chk("valid", valid, m_valid);
        chk("dup", dup, m_dup);
        chk("code", code, m_code);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        m_pend = 0; m_valid = 0; m_code = 0; m_dup = 0; m_ptr = 0;
        @(negedge clk);

        // Reset with all requests asserted.
        step(16'hFFFF, 1'b0, 1'b0);
        step(16'hFFFF, 1'b1, 1'b0);
        chk("rst_pending", pending, 16'h0000);
        chk("rst_valid", valid, 1'b0);
        step(16'h0000, 1'b0, 1'b1);
        chk("idle_cnt", pend_cnt, 5'd0);

        // Single request: valid two edges after req, cleared one edge after handshake.
        step(16'h0020, 1'b1, 1'b1);
        chk("single_pend", pending, 16'h0020);
        chk("single_nvalid", valid, 1'b0);
        step(16'h0000, 1'b1, 1'b1);
        chk("single_valid", valid, 1'b1);
        chk("single_code", code, 4'd5);
        step(16'h0000, 1'b1, 1'b1);
        chk("single_clr_pend", pending, 16'h0000);
        chk("single_clr_valid", valid, 1'b0);

        // Back-to-back grants without bubbles.
        step(16'h0000, 1'b0, 1'b0);
        step(16'h8101, 1'b1, 1'b1);
        chk("b2b_cnt3", pend_cnt, 5'd3);
        step(16'h0000, 1'b1, 1'b1);
        chk("b2b_code0", code, 4'd0);
        step(16'h0000, 1'b1, 1'b1);
        chk("b2b_code8", code, 4'd8);
        chk("b2b_cnt2", pend_cnt, 5'd2);
        step(16'h0000, 1'b1, 1'b1);
        chk("b2b_code15", code, 4'd15);
        chk("b2b_cnt1", pend_cnt, 5'd1);
        step(16'h0000, 1'b1, 1'b1);
        chk("b2b_done_valid", valid, 1'b0);
        chk("b2b_cnt0", pend_cnt, 5'd0);

        // Stall: code held while a higher-priority request arrives.
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0010, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0001, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        chk("stall_code", code, 4'd4);
        chk("stall_dup", dup, 1'b0);
        step(16'h0000, 1'b1, 1'b1);
        chk("stall_next_code", code, 4'd0);
        step(16'h0000, 1'b1, 1'b1);
        chk("stall_drained", valid, 1'b0);

        // Collision: request on the bit being cleared re-arms it; repeat request flags dup.
        step(16'h0000, 1'b0, 1'b0);
        step(16'h0008, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        chk("coll_code", code, 4'd3);
        step(16'h0008, 1'b1, 1'b1);
        chk("coll_pend", pending, 16'h0008);
        chk("coll_recode", code, 4'd3);
        chk("coll_valid", valid, 1'b1);
        step(16'h0008, 1'b0, 1'b1);
        chk("coll_dup_hi", dup, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        chk("coll_dup_lo", dup, 1'b0);

        // Reset during an active handshake discards it.
        step(16'h0000, 1'b1, 1'b0);
        chk("rst_mid_valid", valid, 1'b0);
        chk("rst_mid_pend", pending, 16'h0000);
        chk("rst_mid_code", code, 4'd0);

        // All requests held with ready high: priority order of grants.
        step(16'hFFFF, 1'b1, 1'b1);
        chk("full_cnt", pend_cnt, 5'd16);
        for (int j = 0; j < 18; j++) begin
            step(16'hFFFF, 1'b1, 1'b1);
`ifdef REQ_ENC_ROUND_ROBIN_EN
            chk("rr_code", code, j % 16);
`else
            chk("fixed_code", code, 0);
`endif
        end

        // Random traffic against the model.
        step(16'h0000, 1'b0, 1'b0);
        for (int t = 0; t < 400; t++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            step(r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
